// File: rtl/hybrid_mul_pkg.sv
// hybrid_mul_pkg: shared DSP geometry constants and width helpers for the hybrid multiplier
package hybrid_mul_pkg;
    localparam int DSP_A_W = 24;
    localparam int DSP_B_W = 17;
    localparam int DSP_P_W = 41;
    function automatic int hm_prod_w(input int w);
        return 2 * w;
    endfunction
    function automatic bit hm_w_legal(input int w);
        return (w >= DSP_A_W + 1) && (w <= DSP_B_W + DSP_A_W);
    endfunction
endpackage

// File: rtl/hybrid_mul_pp.sv
// hybrid_mul_pp: registered partial products, large ones on DSP slices, small ones in LUTs
module hybrid_mul_pp
    import hybrid_mul_pkg::*;
#(
    parameter int W = 30
) (
    input  logic                                 clk,
    input  logic                                 i_en,
    input  logic [DSP_A_W-1:0]                   i_a_lo,
    input  logic [W-DSP_A_W-1:0]                 i_a_hi,
    input  logic [DSP_B_W-1:0]                   i_b_lo,
    input  logic [W-DSP_B_W-1:0]                 i_b_hi,
    output logic [DSP_P_W-1:0]                   o_p0,
    output logic [DSP_A_W+W-DSP_B_W-1:0]         o_p1,
    output logic [W-DSP_A_W+DSP_B_W-1:0]         o_p2,
    output logic [2*W-DSP_A_W-DSP_B_W-1:0]       o_p3
);
    localparam int AH = W - DSP_A_W;
    localparam int BH = W - DSP_B_W;
    (* use_dsp = "yes" *) logic [DSP_P_W-1:0]       r_p0;
    (* use_dsp = "yes" *) logic [DSP_A_W+BH-1:0]    r_p1;
    (* use_dsp = "no" *)  logic [AH+DSP_B_W-1:0]    r_p2;
    (* use_dsp = "no" *)  logic [AH+BH-1:0]         r_p3;

    // S2: capture all four partial products when the pipeline advances
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_p0 <= {{DSP_B_W{1'b0}}, i_a_lo} * {{DSP_A_W{1'b0}}, i_b_lo};
            r_p1 <= {{BH{1'b0}}, i_a_lo} * {{DSP_A_W{1'b0}}, i_b_hi};
            r_p2 <= {{DSP_B_W{1'b0}}, i_a_hi} * {{AH{1'b0}}, i_b_lo};
            r_p3 <= {{BH{1'b0}}, i_a_hi} * {{AH{1'b0}}, i_b_hi};
        end
    end

    assign o_p0 = r_p0;
    assign o_p1 = r_p1;
    assign o_p2 = r_p2;
    assign o_p3 = r_p3;
endmodule

// File: rtl/hybrid_mul_pipe.sv
// hybrid_mul_pipe: 4-stage W x W unsigned multiplier with valid/ready, tag and in-flight count
module hybrid_mul_pipe
    import hybrid_mul_pkg::*;
#(
    parameter int W     = 30,
    parameter int TAG_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_a,
    input  logic [W-1:0]              in_b,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [hm_prod_w(W)-1:0]   out_p,
    output logic [TAG_W-1:0]          out_tag,
    output logic [2:0]                inflight
);
    localparam int PW  = hm_prod_w(W);
    localparam int AH  = W - DSP_A_W;
    localparam int BH  = W - DSP_B_W;
    localparam int P1W = DSP_A_W + BH;
    localparam int P2W = AH + DSP_B_W;
    localparam int P3W = AH + BH;

    if (!hm_w_legal(W)) begin : g_bad_w
        $error("hybrid_mul_pipe: W must lie in 25..41");
    end

    logic                 w_adv;
    logic                 w_acc;
    logic                 w_pop;
    logic [4:1]           r_v;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [TAG_W-1:0]     r_t1;
    logic [TAG_W-1:0]     r_t2;
    logic [TAG_W-1:0]     r_t3;
    logic [TAG_W-1:0]     r_t4;
    logic [DSP_P_W-1:0]   w_p0;
    logic [P1W-1:0]       w_p1;
    logic [P2W-1:0]       w_p2;
    logic [P3W-1:0]       w_p3;
    logic [PW-1:0]        w_slo;
    logic [PW-1:0]        w_shi;
    logic [PW-1:0]        r_slo;
    logic [PW-1:0]        r_shi;
    logic [PW-1:0]        r_p;
    logic [2:0]           r_cnt;

    assign w_adv     = !r_v[4] || out_ready;
    assign w_acc     = in_valid && w_adv;
    assign w_pop     = r_v[4] && out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[4];
    assign out_p     = r_p;
    assign out_tag   = r_t4;
    assign inflight  = r_cnt;

    assign w_slo = {{(PW-DSP_P_W){1'b0}}, w_p0} + ({{(PW-P1W){1'b0}}, w_p1} << DSP_B_W);
    assign w_shi = ({{(PW-P2W){1'b0}}, w_p2} << DSP_A_W) + ({{(PW-P3W){1'b0}}, w_p3} << DSP_P_W);

    hybrid_mul_pp #(.W(W)) u_pp (
        .clk    (clk),
        .i_en   (w_adv),
        .i_a_lo (r_a[DSP_A_W-1:0]),
        .i_a_hi (r_a[W-1:DSP_A_W]),
        .i_b_lo (r_b[DSP_B_W-1:0]),
        .i_b_hi (r_b[W-1:DSP_B_W]),
        .o_p0   (w_p0),
        .o_p1   (w_p1),
        .o_p2   (w_p2),
        .o_p3   (w_p3)
    );

    // Unreset datapath: S1 operands, S3 half sums and the tag chain up to S3
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_t1  <= in_tag;
            r_t2  <= r_t1;
            r_t3  <= r_t2;
            r_slo <= w_slo;
            r_shi <= w_shi;
        end
    end

    // Valid chain, output stage S4 and in-flight count; reset drops every beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_p   <= '0;
            r_t4  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_adv) begin
                r_v  <= {r_v[3:1], in_valid};
                r_p  <= r_slo + r_shi;
                r_t4 <= r_t3;
            end
            r_cnt <= r_cnt + {2'b0, w_acc} - {2'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_hybrid_mul_pipe.sv
// tb_hybrid_mul_pipe: W=25/30/41 multipliers in lockstep against a queue-based product model
module tb_hybrid_mul_pipe;
    typedef struct {
        logic [40:0] a;
        logic [40:0] b;
        logic [7:0]  tag;
        logic [59:0] p;
    } vec_t;
    typedef struct {
        logic [40:0] a;
        logic [40:0] b;
        logic [7:0]  tag;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic [40:0] in_a;
    logic [40:0] in_b;
    logic [7:0]  in_tag;

    logic ov25, ov30, ov41, ir25, ir30, ir41;
    logic [49:0] p25;
    logic [59:0] p30;
    logic [81:0] p41;
    logic [7:0]  t25, t30, t41;
    logic [2:0]  f25, f30, f41;

    logic        ov[3];
    logic        ir[3];
    logic [81:0] op[3];
    logic [7:0]  ot[3];
    logic [2:0]  inf[3];
    int          ws[3] = '{25, 30, 41};

    int errs = 0;
    int checks = 0;
    int ncyc = 0;
    int exp_ov = -1;
    int exp_idx = -1;
    logic last_acc;
    beat_t q[$];
    vec_t tab[7];

    always #5 clk = ~clk;

    hybrid_mul_pipe #(.W(25), .TAG_W(8)) u25 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir25),
        .in_a(in_a[24:0]), .in_b(in_b[24:0]), .in_tag(in_tag),
        .out_valid(ov25), .out_ready(out_ready), .out_p(p25), .out_tag(t25), .inflight(f25));
    hybrid_mul_pipe #(.W(30), .TAG_W(8)) u30 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir30),
        .in_a(in_a[29:0]), .in_b(in_b[29:0]), .in_tag(in_tag),
        .out_valid(ov30), .out_ready(out_ready), .out_p(p30), .out_tag(t30), .inflight(f30));
    hybrid_mul_pipe #(.W(41), .TAG_W(8)) u41 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir41),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov41), .out_ready(out_ready), .out_p(p41), .out_tag(t41), .inflight(f41));

    assign ov[0] = ov25;
    assign ov[1] = ov30;
    assign ov[2] = ov41;
    assign ir[0] = ir25;
    assign ir[1] = ir30;
    assign ir[2] = ir41;
    assign op[0] = {32'b0, p25};
    assign op[1] = {22'b0, p30};
    assign op[2] = p41;
    assign ot[0] = t25;
    assign ot[1] = t30;
    assign ot[2] = t41;
    assign inf[0] = f25;
    assign inf[1] = f30;
    assign inf[2] = f41;

    function automatic logic [81:0] ref_p(input logic [40:0] a, input logic [40:0] b, input int w);
        logic [40:0] m;
        m = (41'(1) << w) - 41'(1);
        return {41'b0, a & m} * {41'b0, b & m};
    endfunction

    function automatic logic [40:0] rnd_op();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return 41'({$urandom, $urandom});
    endfunction

    task automatic chk(input string n, input logic [81:0] act, input logic [81:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", n, act, exp, ncyc);
        end
    endtask

    task automatic tick();
        logic acc;
        logic pop;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready_w%0d", ws[k]), 82'(ir[k]), 82'(!ov[k] || out_ready));
            chk($sformatf("inflight_w%0d", ws[k]), 82'(inf[k]), 82'(q.size()));
            if (exp_ov >= 0) chk($sformatf("out_valid_w%0d", ws[k]), 82'(ov[k]), 82'(exp_ov));
            if (ov[k]) begin
                if (q.size() == 0) chk($sformatf("stale_beat_w%0d", ws[k]), 82'(ov[k]), 82'(0));
                else begin
                    chk($sformatf("out_p_w%0d", ws[k]), op[k], ref_p(q[0].a, q[0].b, ws[k]));
                    chk($sformatf("out_tag_w%0d", ws[k]), 82'(ot[k]), 82'(q[0].tag));
                end
            end
        end
        if (exp_idx >= 0) begin
            chk($sformatf("tab_p_%0d", exp_idx), op[1], 82'(tab[exp_idx].p));
            chk($sformatf("tab_tag_%0d", exp_idx), 82'(ot[1]), 82'(tab[exp_idx].tag));
        end
        acc = in_valid && ir[1];
        pop = ov[1] && out_ready;
        last_acc = acc;
        @(posedge clk);
        if (pop && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back('{in_a, in_b, in_tag});
        ncyc++;
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        int nbeats;
        logic [81:0] held;
        tab[0] = '{41'h3FFFFFFF, 41'h3FFFFFFF, 8'h5A, 60'h0FFFFFFF80000001};
        tab[1] = '{41'd1, 41'd1, 8'd1, 60'd1};
        tab[2] = '{41'h1000000, 41'h20000, 8'd2, 60'h20000000000};
        tab[3] = '{41'h123456, 41'h2ABCDEF, 8'd3, 60'h30A04659BA4A};
        tab[4] = '{41'd0, 41'h2ABCDEF, 8'h44, 60'd0};
        tab[5] = '{41'h1ABCDEF1, 41'd0, 8'h55, 60'd0};
        tab[6] = '{41'h20000000, 41'h20000000, 8'h66, 60'h400000000000000};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid_w%0d", ws[k]), 82'(ov[k]), 82'(0));
            chk($sformatf("rst_in_ready_w%0d", ws[k]), 82'(ir[k]), 82'(1));
            chk($sformatf("rst_out_p_w%0d", ws[k]), op[k], 82'(0));
            chk($sformatf("rst_out_tag_w%0d", ws[k]), 82'(ot[k]), 82'(0));
            chk($sformatf("rst_inflight_w%0d", ws[k]), 82'(inf[k]), 82'(0));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // back-to-back table beats, each expected exactly four edges after acceptance
        for (int c = 0; c < 7 + 5; c++) begin
            in_valid = c < 7;
            if (c < 7) begin
                in_a = tab[c].a;
                in_b = tab[c].b;
                in_tag = tab[c].tag;
            end
            exp_idx = (c >= 4 && c - 4 < 7) ? c - 4 : -1;
            exp_ov = exp_idx >= 0 ? 1 : 0;
            tick();
        end
        exp_idx = -1;

        // stall: six beats offered with out_ready low, only four fit
        out_ready = 1'b0;
        in_valid = 1'b1;
        nacc = 0;
        held = '0;
        for (int c = 0; c < 6; c++) begin
            in_a = 41'(1000 + nacc * 77);
            in_b = 41'(3000000 + nacc * 12345);
            in_tag = 8'(8'h80 + nacc);
            exp_ov = c >= 4 ? 1 : 0;
            tick();
            nacc += int'(last_acc);
            if (c == 4) held = op[1];
            if (c == 5) chk("stall_out_p_stable", op[1], held);
        end
        chk("stall_accepted", 82'(nacc), 82'(4));
        chk("stall_inflight", 82'(inf[1]), 82'(4));
        chk("stall_in_ready", 82'(ir[1]), 82'(0));
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp_ov = c < 4 ? 1 : 0;
            tick();
        end
        chk("stall_drained", 82'(q.size()), 82'(0));

        // reset with three beats in flight
        exp_ov = -1;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_a = rnd_op();
            in_b = rnd_op();
            in_tag = 8'(c + 1);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst_out_valid_w%0d", ws[k]), 82'(ov[k]), 82'(0));
            chk($sformatf("midrst_inflight_w%0d", ws[k]), 82'(inf[k]), 82'(0));
        end
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_ov = 0;
        repeat (4) tick();
        in_valid = 1'b1;
        in_a = 41'h3FFFFFFF;
        in_b = 41'h2ABCDEF;
        in_tag = 8'hC3;
        tick();
        chk("post_rst_accept", 82'(last_acc), 82'(1));
        in_valid = 1'b0;
        repeat (3) tick();
        exp_ov = 1;
        tick();
        exp_ov = 0;
        tick();

        // random traffic with random back-pressure
        exp_ov = -1;
        nbeats = 0;
        while (nbeats < 10000 && ncyc < 60000) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 1) == 1;
            in_a = rnd_op();
            in_b = rnd_op();
            in_tag = 8'($urandom);
            tick();
            nbeats += int'(last_acc);
        end
        chk("random_beats", 82'(nbeats), 82'(10000));
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("random_drained", 82'(q.size()), 82'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
